// File: rtl/fetch_predict_unit.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit saturating
// direction counters. Resolutions from Execute train the table and raise a
// redirect when the carried-down prediction proves wrong.

// One BTB entry. Only valid and ctr are reset; tag and target are don't-care
// until the entry is first allocated.
module fetch_btb_entry #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_target,
  input  logic [1:0]            wr_ctr,
  output logic                  valid,
  output logic [TAG_W-1:0]      tag,
  output logic [DATA_WIDTH-1:0] target,
  output logic [1:0]            ctr
);

  // Valid and counter state: cleared to invalid / weakly-not-taken on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctr   <= 2'b01;
    end else if (wr_en) begin
      valid <= 1'b1;
      ctr   <= wr_ctr;
    end
  end

  // Tag and target payload: written on update, never reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      tag    <= wr_tag;
      target <= wr_target;
    end
  end

endmodule

module fetch_predict_unit #(
  parameter int                      DATA_WIDTH     = 32,
  parameter int                      BTB_INDEX_BITS = 6,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic [DATA_WIDTH-1:0] ImemRdataF,
  output logic [DATA_WIDTH-1:0] ImemAddrF,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  PredictTakenF,
  input  logic                  ResolveE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PCPlus4E,
  input  logic                  ActualTakenE,
  input  logic [DATA_WIDTH-1:0] ActualTargetE,
  input  logic                  PredictTakenE,
  input  logic [DATA_WIDTH-1:0] PredTargetE,
  output logic                  MispredictE
);

  localparam int ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int TAG_W   = DATA_WIDTH - BTB_INDEX_BITS - 2;

  logic [DATA_WIDTH-1:0]              pc_q, pc_next, redirect_pc, pred_target;
  logic [ENTRIES-1:0]                 ent_valid, ent_wr;
  logic [ENTRIES-1:0][TAG_W-1:0]      ent_tag;
  logic [ENTRIES-1:0][DATA_WIDTH-1:0] ent_target;
  logic [ENTRIES-1:0][1:0]            ent_ctr;

  logic [BTB_INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]          f_tag, u_tag;
  logic                      f_hit, u_hit, u_write;
  logic [1:0]                u_ctr_old, u_ctr_new;
  logic [DATA_WIDTH-1:0]     u_target_new;
  logic                      unused_pce_lsbs;

  assign unused_pce_lsbs = ^PCE[1:0];

  // Fetch-side outputs straight off the PC register.
  assign PCF       = pc_q;
  assign ImemAddrF = pc_q;
  assign PCPlus4F  = pc_q + DATA_WIDTH'(4);
  assign InstrF    = ImemRdataF;

  // Combinational lookup on the fetch PC; sees pre-update table contents.
  assign f_idx         = pc_q[BTB_INDEX_BITS+1:2];
  assign f_tag         = pc_q[DATA_WIDTH-1:BTB_INDEX_BITS+2];
  assign f_hit         = ent_valid[f_idx] && (ent_tag[f_idx] == f_tag);
  assign PredictTakenF = f_hit && ent_ctr[f_idx][1];
  assign pred_target   = ent_target[f_idx];

  // Wrong direction, or right "taken" with the wrong target, forces a redirect.
  assign MispredictE = ResolveE &&
                       ((PredictTakenE != ActualTakenE) ||
                        (PredictTakenE && ActualTakenE && (PredTargetE != ActualTargetE)));
  assign redirect_pc = ActualTakenE ? ActualTargetE : PCPlus4E;

  // Next-PC selection: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_next = PCPlus4F;
    if (MispredictE)        pc_next = redirect_pc;
    else if (StallF)        pc_next = pc_q;
    else if (PredictTakenF) pc_next = pred_target;
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_next;
  end

  // Update-side lookup on the resolving PC.
  assign u_idx     = PCE[BTB_INDEX_BITS+1:2];
  assign u_tag     = PCE[DATA_WIDTH-1:BTB_INDEX_BITS+2];
  assign u_hit     = ent_valid[u_idx] && (ent_tag[u_idx] == u_tag);
  assign u_ctr_old = ent_ctr[u_idx];
  // Not-taken misses leave the table alone so they cannot evict live entries.
  assign u_write   = ResolveE && !rst && (u_hit || ActualTakenE);

  // New counter/target: saturating train on hit, weakly-taken on allocate.
  always_comb begin
    u_ctr_new    = 2'b10;
    u_target_new = ActualTargetE;
    if (u_hit) begin
      if (ActualTakenE) u_ctr_new = (u_ctr_old == 2'b11) ? 2'b11 : u_ctr_old + 2'd1;
      else              u_ctr_new = (u_ctr_old == 2'b00) ? 2'b00 : u_ctr_old - 2'd1;
      if (!ActualTakenE) u_target_new = ent_target[u_idx];
    end
  end

  // Per-entry storage; exactly one entry sees the write strobe.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_btb
    assign ent_wr[i] = u_write && (u_idx == BTB_INDEX_BITS'(i));
    fetch_btb_entry #(.DATA_WIDTH(DATA_WIDTH), .TAG_W(TAG_W)) u_ent (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (ent_wr[i]),
      .wr_tag    (u_tag),
      .wr_target (u_target_new),
      .wr_ctr    (u_ctr_new),
      .valid     (ent_valid[i]),
      .tag       (ent_tag[i]),
      .target    (ent_target[i]),
      .ctr       (ent_ctr[i])
    );
  end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit: sequential fetch, BTB training,
// counter hysteresis, stall/redirect priority, aliasing, reset discard.
module tb_fetch_predict_unit;

  logic        clk = 1'b0;
  logic        rst, StallF, ResolveE, ActualTakenE, PredictTakenE;
  logic [31:0] ImemRdataF, PCE, PCPlus4E, ActualTargetE, PredTargetE;
  logic [31:0] ImemAddrF, InstrF, PCF, PCPlus4F;
  logic        PredictTakenF, MispredictE;
  int          passed = 0, total = 0;

  fetch_predict_unit dut (
    .clk(clk), .rst(rst), .StallF(StallF), .ImemRdataF(ImemRdataF),
    .ImemAddrF(ImemAddrF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .PredictTakenF(PredictTakenF), .ResolveE(ResolveE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .ActualTakenE(ActualTakenE), .ActualTargetE(ActualTargetE),
    .PredictTakenE(PredictTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_resolve();
    ResolveE = 0; PCE = 0; PCPlus4E = 0; ActualTakenE = 0;
    ActualTargetE = 0; PredictTakenE = 0; PredTargetE = 0;
  endtask

  // Steer the PC via a not-taken mispredict from a PC that never allocates.
  task automatic redirect(input logic [31:0] a);
    ResolveE = 1; PCE = 32'h200; PCPlus4E = a; ActualTakenE = 0; PredictTakenE = 1;
    tick(); idle_resolve(); #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    ResolveE = 1; PCE = pc; PCPlus4E = pc + 4; ActualTakenE = tk;
    ActualTargetE = tgt; PredictTakenE = ptk; PredTargetE = ptgt;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; StallF = 0; ImemRdataF = 32'hDEAD_BEEF; idle_resolve();
    tick(); tick(); rst = 0; #1;
    total++; if (PCF !== 32'h0) $display("FAIL rst_pcf got %h exp %h", PCF, 32'h0); else passed++;
    total++; if (PCPlus4F !== 32'h4) $display("FAIL rst_pcplus4 got %h exp %h", PCPlus4F, 32'h4); else passed++;
    total++; if (PredictTakenF !== 1'b0) $display("FAIL rst_pred got %b exp 0", PredictTakenF); else passed++;
    total++; if (MispredictE !== 1'b0) $display("FAIL rst_misp got %b exp 0", MispredictE); else passed++;
    total++; if (InstrF !== 32'hDEAD_BEEF) $display("FAIL instr_pass got %h exp deadbeef", InstrF); else passed++;
  endtask

  task automatic test_free_run();
    logic [31:0] exp;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = 32'(i * 4);
      total++; if (PCF !== exp) $display("FAIL run_pcf%0d got %h exp %h", i, PCF, exp); else passed++;
      total++; if (ImemAddrF !== exp) $display("FAIL run_addr%0d got %h exp %h", i, ImemAddrF, exp); else passed++;
      total++; if (PCPlus4F !== exp + 4) $display("FAIL run_p4_%0d got %h exp %h", i, PCPlus4F, exp + 4); else passed++;
      total++; if (PredictTakenF !== 1'b0) $display("FAIL run_pred%0d got %b exp 0", i, PredictTakenF); else passed++;
    end
  endtask

  task automatic test_cold_taken();
    resolve(32'h10, 1, 32'h40, 0, 32'h0);
    total++; if (MispredictE !== 1'b1) $display("FAIL cold_misp got %b exp 1", MispredictE); else passed++;
    tick(); idle_resolve(); #1;
    total++; if (PCF !== 32'h40) $display("FAIL cold_redir got %h exp 40", PCF); else passed++;
    redirect(32'h10);
    total++; if (PredictTakenF !== 1'b1) $display("FAIL cold_pred got %b exp 1", PredictTakenF); else passed++;
    tick();
    total++; if (PCF !== 32'h40) $display("FAIL cold_follow got %h exp 40", PCF); else passed++;
  endtask

  task automatic test_hysteresis();
    // ctr 10 -> 01
    resolve(32'h10, 0, 32'h0, 1, 32'h40);
    total++; if (MispredictE !== 1'b1) $display("FAIL hys_nt_misp got %b exp 1", MispredictE); else passed++;
    tick(); idle_resolve();
    redirect(32'h10);
    total++; if (PredictTakenF !== 1'b0) $display("FAIL hys_01 got %b exp 0", PredictTakenF); else passed++;
    // 01 -> 10 -> 11 -> 11, correctly predicted so no redirect
    for (int i = 0; i < 3; i++) begin
      resolve(32'h10, 1, 32'h40, 1, 32'h40);
      total++; if (MispredictE !== 1'b0) $display("FAIL hys_tk_misp%0d got %b exp 0", i, MispredictE); else passed++;
      tick();
    end
    idle_resolve();
    // 11 -> 10, still taken
    resolve(32'h10, 0, 32'h0, 0, 32'h0);
    tick(); idle_resolve();
    redirect(32'h10);
    total++; if (PredictTakenF !== 1'b1) $display("FAIL hys_sat got %b exp 1", PredictTakenF); else passed++;
    tick();
    total++; if (PCF !== 32'h40) $display("FAIL hys_tgt got %h exp 40", PCF); else passed++;
  endtask

  task automatic test_stall();
    StallF = 1;
    ResolveE = 1; PCE = 32'h20; PCPlus4E = 32'h24; ActualTakenE = 0; PredictTakenE = 1; #1;
    total++; if (MispredictE !== 1'b1) $display("FAIL stall_misp got %b exp 1", MispredictE); else passed++;
    tick(); idle_resolve(); #1;
    total++; if (PCF !== 32'h24) $display("FAIL stall_redir got %h exp 24", PCF); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (PCF !== 32'h24) $display("FAIL stall_hold%0d got %h exp 24", i, PCF); else passed++;
    end
    StallF = 0;
    tick();
    total++; if (PCF !== 32'h28) $display("FAIL stall_release got %h exp 28", PCF); else passed++;
  endtask

  task automatic test_alias_target();
    redirect(32'h110);
    total++; if (PredictTakenF !== 1'b0) $display("FAIL alias_pred got %b exp 0", PredictTakenF); else passed++;
    tick();
    total++; if (PCF !== 32'h114) $display("FAIL alias_next got %h exp 114", PCF); else passed++;
    resolve(32'h10, 1, 32'h80, 1, 32'h40);
    total++; if (MispredictE !== 1'b1) $display("FAIL tgt_misp got %b exp 1", MispredictE); else passed++;
    tick(); idle_resolve(); #1;
    total++; if (PCF !== 32'h80) $display("FAIL tgt_redir got %h exp 80", PCF); else passed++;
    redirect(32'h10);
    total++; if (PredictTakenF !== 1'b1) $display("FAIL tgt_pred got %b exp 1", PredictTakenF); else passed++;
    tick();
    total++; if (PCF !== 32'h80) $display("FAIL tgt_new got %h exp 80", PCF); else passed++;
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    total++; if (PCPlus4F !== 32'h0) $display("FAIL wrap_p4 got %h exp 0", PCPlus4F); else passed++;
    tick();
    total++; if (PCF !== 32'h0) $display("FAIL wrap_pc got %h exp 0", PCF); else passed++;
  endtask

  task automatic test_nt_miss_and_reset();
    resolve(32'h30, 0, 32'h0, 0, 32'h0);
    total++; if (MispredictE !== 1'b0) $display("FAIL ntm_misp got %b exp 0", MispredictE); else passed++;
    tick(); idle_resolve();
    redirect(32'h30);
    total++; if (PredictTakenF !== 1'b0) $display("FAIL ntm_alloc got %b exp 0", PredictTakenF); else passed++;
    redirect(32'h54);
    // Reset alongside a mispredict that would also allocate 0x50.
    rst = 1;
    resolve(32'h50, 1, 32'h90, 0, 32'h0);
    total++; if (MispredictE !== 1'b1) $display("FAIL rstm_misp got %b exp 1", MispredictE); else passed++;
    tick(); rst = 0; idle_resolve(); #1;
    total++; if (PCF !== 32'h0) $display("FAIL rstm_pc got %h exp 0", PCF); else passed++;
    redirect(32'h10);
    total++; if (PredictTakenF !== 1'b0) $display("FAIL rstm_clear got %b exp 0", PredictTakenF); else passed++;
    redirect(32'h50);
    total++; if (PredictTakenF !== 1'b0) $display("FAIL rstm_noupd got %b exp 0", PredictTakenF); else passed++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_cold_taken();
    test_hysteresis();
    test_stall();
    test_alias_target();
    test_wrap();
    test_nt_miss_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
Fetch-stage producer for the F/D pipeline register. It owns the PC register, drives the instruction-memory address, and predicts branches using a direct-mapped BTB with 2-bit saturating counters. Branch outcomes resolved in Execute update the predictor, and the unit raises a mispredict redirect. Its outputs InstrF, PCF, PCPlus4F and PredictTakenF feed the F/D register directly.

Parameters:
DATA_WIDTH, 32, width of PC, instruction and target buses
BTB_INDEX_BITS, 6, log2 of BTB entries (64); index = PC[BTB_INDEX_BITS+1:2]
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
StallF  in  1  hold PC (from hazard unit)
ImemRdataF  in  DATA_WIDTH  instruction-memory read data for ImemAddrF
ImemAddrF  out  DATA_WIDTH  instruction-memory address (= PCF)
InstrF  out  DATA_WIDTH  = ImemRdataF (combinational pass-through)
PCF  out  DATA_WIDTH  current fetch PC
PCPlus4F  out  DATA_WIDTH  PCF + 4
PredictTakenF  out  1  BTB predicts taken for PCF
ResolveE  in  1  branch/jump in E resolved this cycle; one-cycle pulse per instruction
PCE  in  DATA_WIDTH  PC of resolving instruction
PCPlus4E  in  DATA_WIDTH  fall-through of resolving instruction
ActualTakenE  in  1  resolved direction
ActualTargetE  in  DATA_WIDTH  resolved target
PredictTakenE  in  1  prediction carried down pipe
PredTargetE  in  DATA_WIDTH  predicted target carried down pipe
MispredictE  out  1  redirect; hazard unit flushes D and E

Behaviour:
- Reset (rst=1 at posedge): PC <= RESET_PC; all BTB valid bits <= 0; all counters <= 2'b01. Table contents otherwise don't-care. In the following cycle: PCF=RESET_PC, PCPlus4F=RESET_PC+4, PredictTakenF=0, MispredictE reflects inputs only. Reset mid-operation discards any redirect or update in that cycle.
- Entry fields: valid, tag = PC[DATA_WIDTH-1:BTB_INDEX_BITS+2], target[DATA_WIDTH-1:0], ctr[1:0].
- Lookup is combinational on PCF. Hit = valid & tag match. PredictTakenF = hit & ctr[1]. PredTarget = entry target.
- MispredictE is combinational: ResolveE & ((PredictTakenE != ActualTakenE) | (PredictTakenE & ActualTakenE & (PredTargetE != ActualTargetE))).
- RedirectPC = ActualTakenE ? ActualTargetE : PCPlus4E.
- Next-PC priority at posedge: rst > MispredictE (RedirectPC, overrides StallF) > StallF (hold) > PredictTakenF (PredTarget) > PCPlus4F.
- All PC arithmetic is modulo 2^DATA_WIDTH; 0xFFFF_FFFC + 4 wraps to 0.
- Update on ResolveE (independent of StallF), index/tag taken from PCE:
  - Hit: ctr saturating +1 if taken, -1 if not (11 and 00 saturate). Target <= ActualTargetE if taken.
  - Miss & taken: allocate (overwriting any alias) with valid=1, tag, target=ActualTargetE, ctr=2'b10.
  - Miss & not taken: no write.
- Read-before-write: a same-cycle lookup at the index being updated sees the old entry; the new entry is visible from the next cycle.
- Single update port. One resolution per cycle maximum.

Test Plan:
1. Reset, then free-run with StallF=0 and no ResolveE -> PCF sequence 0x0, 0x4, 0x8, 0xC. PCPlus4F = PCF+4. PredictTakenF=0 throughout.
2. Cold taken branch: ResolveE with PCE=0x10, ActualTakenE=1, ActualTargetE=0x40, PredictTakenE=0 -> MispredictE=1 and next PCF=0x40. On the next fetch of 0x10: PredictTakenF=1 and the following PCF=0x40.
3. Counter hysteresis on entry 0x10 (ctr=10): one not-taken resolve -> ctr 01, PredictTakenF=0 at 0x10. Three taken resolves -> ctr saturates at 11. One not-taken -> ctr 10, still predicts taken.
4. StallF=1 and MispredictE=1 in the same cycle (not-taken redirect, PCPlus4E=0x24) -> PCF=0x24 next cycle. With StallF=1 and no mispredict, PCF holds for 3 cycles.
5. Alias and wrong target: entry at 0x10 valid; fetch 0x110 (same index, different tag) -> PredictTakenF=0. Resolve at 0x10 with PredictTakenE=1, PredTargetE=0x40, ActualTargetE=0x80 -> MispredictE=1, next PCF=0x80, stored target becomes 0x80.
6. Not-taken miss at PCE=0x30 -> MispredictE=0, no allocation (later fetch of 0x30 predicts 0). Assert rst in the same cycle as a mispredict -> next PCF=RESET_PC, BTB cleared.
